spi_command_decoder: RTL and testbench

SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

---
 rtl/spi_command_decoder.sv | 184 ++++++++++++++++++
 tb/tb_spi_command_decoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_decoder.sv
// Byte-stream command decoder for an SPI slave: assembles opcode/address/value frames
// and supplies the reply bytes for STREAM and TRANSFER.
module spi_command_decoder #(
  parameter int unsigned ADDRESS_BYTES  = 3,
  parameter int unsigned VALUE_BYTES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       spi_rx_valid_i,
  input  logic [7:0]                 spi_rx_byte_i,
  input  logic                       cs_n_i,
  input  logic [8*VALUE_BYTES-1:0]   result_i,
  input  logic [8*VALUE_BYTES-1:0]   stream_i,
  output logic [7:0]                 instruction_o,
  output logic [8*ADDRESS_BYTES-1:0] address_o,
  output logic [8*VALUE_BYTES-1:0]   value_o,
  output logic                       cmd_valid_o,
  output logic [7:0]                 spi_tx_byte_o,
  output logic                       abort_o,
  output logic                       error_o
);

  localparam int unsigned AW = 8 * ADDRESS_BYTES;
  localparam int unsigned VW = 8 * VALUE_BYTES;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] ToLast = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OpWrite    = 8'd1;
  localparam logic [7:0] OpRead     = 8'd2;
  localparam logic [7:0] OpStream   = 8'd3;
  localparam logic [7:0] OpBindInt  = 8'd4;
  localparam logic [7:0] OpBindRd   = 8'd5;
  localparam logic [7:0] OpBindWr   = 8'd6;
  localparam logic [7:0] OpTransfer = 8'd7;
  localparam logic [7:0] OpRepeat   = 8'd8;

  typedef enum logic {StIdle, StCollect} state_t;

  state_t          r_state;
  logic [7:0]      r_op;
  logic [3:0]      r_plen;
  logic [3:0]      r_cnt;
  logic            r_has_addr;
  logic [AW-1:0]   r_addr;
  logic [VW-1:0]   r_val;
  logic [VW-1:0]   r_stream;
  logic [VW-1:0]   r_result;
  logic [1:0]      r_tidx;
  logic [TW-1:0]   r_to;

  logic            w_accept;
  logic            w_bad_op;
  logic            w_last;
  logic            w_to_addr;
  logic [AW-1:0]   w_addr_nxt;
  logic [VW-1:0]   w_val_nxt;
  logic [VW-1:0]   w_res_sh;
  logic [1:0]      w_tidx_nxt;

  // Payload bytes that follow the opcode.
  function automatic logic [3:0] f_plen(input logic [7:0] op);
    logic [3:0] len;
    len = 4'd0;
    unique case (op)
      OpWrite:                                len = 4'(ADDRESS_BYTES + VALUE_BYTES);
      OpRead, OpBindInt, OpBindRd, OpBindWr:  len = 4'(ADDRESS_BYTES);
      OpStream:                               len = 4'(VALUE_BYTES);
      default:                                len = 4'd0;
    endcase
    return len;
  endfunction

  assign w_accept   = spi_rx_valid_i && !cs_n_i;
  assign w_bad_op   = (spi_rx_byte_i == 8'd0) || (spi_rx_byte_i > 8'd8);
  assign w_last     = (r_cnt == r_plen - 4'd1);
  assign w_to_addr  = r_has_addr && (r_cnt < 4'(ADDRESS_BYTES));
  assign w_addr_nxt = w_to_addr ? ((r_addr << 8) | AW'(spi_rx_byte_i)) : r_addr;
  assign w_val_nxt  = w_to_addr ? r_val : ((r_val << 8) | VW'(spi_rx_byte_i));
  assign w_res_sh   = r_result << {r_tidx, 3'b000};
  assign w_tidx_nxt = (r_tidx == 2'(VALUE_BYTES - 1)) ? 2'd0 : r_tidx + 2'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_op          <= '0;
      r_plen        <= '0;
      r_cnt         <= '0;
      r_has_addr    <= 1'b0;
      r_addr        <= '0;
      r_val         <= '0;
      r_stream      <= '0;
      r_result      <= '0;
      r_tidx        <= '0;
      r_to          <= '0;
      instruction_o <= '0;
      address_o     <= '0;
      value_o       <= '0;
      cmd_valid_o   <= 1'b0;
      spi_tx_byte_o <= '0;
      abort_o       <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      abort_o     <= 1'b0;
      error_o     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_bad_op) begin
              error_o <= 1'b1;
            end else if (spi_rx_byte_i == OpTransfer || spi_rx_byte_i == OpRepeat) begin
              cmd_valid_o   <= 1'b1;
              instruction_o <= spi_rx_byte_i;
              address_o     <= '0;
              value_o       <= '0;
              if (spi_rx_byte_i == OpTransfer) begin
                // Index 0 starts a new snapshot of result_i.
                if (r_tidx == 2'd0) begin
                  r_result      <= result_i;
                  spi_tx_byte_o <= result_i[VW-1 -: 8];
                end else begin
                  spi_tx_byte_o <= w_res_sh[VW-1 -: 8];
                end
                r_tidx <= w_tidx_nxt;
              end else begin
                r_tidx <= 2'd0;
              end
            end else begin
              r_state    <= StCollect;
              r_op       <= spi_rx_byte_i;
              r_plen     <= f_plen(spi_rx_byte_i);
              r_cnt      <= '0;
              r_has_addr <= (spi_rx_byte_i != OpStream);
              r_addr     <= '0;
              r_val      <= '0;
              r_to       <= '0;
              if (spi_rx_byte_i == OpStream) begin
                r_stream      <= stream_i << 8;
                spi_tx_byte_o <= stream_i[VW-1 -: 8];
              end
            end
          end
        end
        StCollect: begin
          if (cs_n_i) begin
            r_state <= StIdle;
            abort_o <= 1'b1;
            r_addr  <= '0;
            r_val   <= '0;
          end else if (spi_rx_valid_i) begin
            r_to   <= '0;
            r_cnt  <= r_cnt + 4'd1;
            r_addr <= w_addr_nxt;
            r_val  <= w_val_nxt;
            if (r_op == OpStream) begin
              // Snapshot shifts left so zeros follow its last byte.
              spi_tx_byte_o <= r_stream[VW-1 -: 8];
              r_stream      <= r_stream << 8;
            end
            if (w_last) begin
              r_state       <= StIdle;
              cmd_valid_o   <= 1'b1;
              instruction_o <= r_op;
              address_o     <= w_addr_nxt;
              value_o       <= w_val_nxt;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (r_to == ToLast) begin
              r_state <= StIdle;
              abort_o <= 1'b1;
              r_addr  <= '0;
              r_val   <= '0;
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_command_decoder.sv
// Bench for spi_command_decoder: directed vector table, timeout/reset sequences and
// randomized traffic against a frame-level byte-queue model.
module tb_spi_command_decoder;
  localparam int A = 3;
  localparam int V = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        cs_n;
  logic [31:0] result;
  logic [31:0] stream;
  logic [7:0]  instruction;
  logic [23:0] address;
  logic [31:0] value;
  logic        cmd_valid;
  logic [7:0]  tx_byte;
  logic        abort;
  logic        error;

  always #5 clk = ~clk;

  spi_command_decoder #(
    .ADDRESS_BYTES (A),
    .VALUE_BYTES   (V),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_rx_valid_i(rx_valid),
    .spi_rx_byte_i (rx_byte),
    .cs_n_i        (cs_n),
    .result_i      (result),
    .stream_i      (stream),
    .instruction_o (instruction),
    .address_o     (address),
    .value_o       (value),
    .cmd_valid_o   (cmd_valid),
    .spi_tx_byte_o (tx_byte),
    .abort_o       (abort),
    .error_o       (error)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: current frame bytes, remaining stream bytes, transfer snapshot.
  logic [7:0]  frame_q[$];
  logic [7:0]  stream_q[$];
  logic [7:0]  res_snap[V];
  int          tidx;
  int          idle;
  logic        m_cmd, m_abort, m_err;
  logic [7:0]  m_tx, m_instr;
  logic [23:0] m_addr;
  logic [31:0] m_val;

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'd1:                   return 1 + A + V;
      8'd2, 8'd4, 8'd5, 8'd6: return 1 + A;
      8'd3:                   return 1 + V;
      default:                return 1;
    endcase
  endfunction

  task automatic model_reset();
    frame_q.delete();
    stream_q.delete();
    for (int i = 0; i < V; i++) res_snap[i] = 8'h00;
    tidx = 0; idle = 0;
    m_cmd = 0; m_abort = 0; m_err = 0;
    m_tx = 0; m_instr = 0; m_addr = 0; m_val = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic cs);
    m_cmd = 0; m_abort = 0; m_err = 0;
    if (frame_q.size() != 0) begin
      if (cs) begin
        m_abort = 1;
        frame_q.delete();
      end else if (v) begin
        frame_q.push_back(b);
        idle = 0;
        if (frame_q[0] == 8'd3) begin
          if (stream_q.size() != 0) m_tx = stream_q.pop_front();
          else m_tx = 8'h00;
        end
        if (frame_q.size() == frame_len(frame_q[0])) begin
          m_cmd = 1; m_instr = frame_q[0]; m_addr = 0; m_val = 0;
          for (int i = 1; i < frame_q.size(); i++) begin
            if (frame_q[0] != 8'd3 && i <= A) m_addr = {m_addr[15:0], frame_q[i]};
            else m_val = {m_val[23:0], frame_q[i]};
          end
          frame_q.delete();
        end
      end else begin
        idle++;
        if (idle == T) begin
          m_abort = 1;
          frame_q.delete();
        end
      end
    end else if (v && !cs) begin
      if (b == 8'd0 || b > 8'd8) begin
        m_err = 1;
      end else if (b == 8'd7) begin
        if (tidx == 0) for (int i = 0; i < V; i++) res_snap[i] = result[8*(V-1-i) +: 8];
        m_tx = res_snap[tidx];
        tidx = (tidx + 1) % V;
        m_cmd = 1; m_instr = b; m_addr = 0; m_val = 0;
      end else if (b == 8'd8) begin
        tidx = 0;
        m_cmd = 1; m_instr = b; m_addr = 0; m_val = 0;
      end else begin
        frame_q.push_back(b);
        idle = 0;
        if (b == 8'd3) begin
          stream_q.delete();
          for (int i = 0; i < V; i++) stream_q.push_back(stream[8*(V-1-i) +: 8]);
          m_tx = stream_q.pop_front();
        end
      end
    end
  endtask

  task automatic apply(input logic v, input logic [7:0] b, input logic cs);
    rx_valid = v; rx_byte = b; cs_n = cs;
    model_step(v, b, cs);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cmd_valid"}, cmd_valid, m_cmd);
    chk({tag, ".abort"}, abort, m_abort);
    chk({tag, ".error"}, error, m_err);
    chk({tag, ".tx"}, tx_byte, m_tx);
    chk({tag, ".instr"}, instruction, m_instr);
    chk({tag, ".addr"}, address, m_addr);
    chk({tag, ".value"}, value, m_val);
    chk({tag, ".exclusive"}, (32'(cmd_valid) + 32'(abort) + 32'(error)) <= 1, 1);
  endtask

  typedef struct {
    logic v; logic [7:0] b; logic cs;
    logic cmd; logic ab; logic er;
    logic [7:0] tx; logic [7:0] ins; logic [23:0] ad; logic [31:0] va;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic v, input logic [7:0] b, input logic cs, input logic cmd,
                      input logic ab, input logic er, input logic [7:0] tx,
                      input logic [7:0] ins, input logic [23:0] ad, input logic [31:0] va);
    vec_t e;
    e.v = v; e.b = b; e.cs = cs; e.cmd = cmd; e.ab = ab; e.er = er;
    e.tx = tx; e.ins = ins; e.ad = ad; e.va = va;
    vecs.push_back(e);
  endtask

  initial begin
    int first_abort;
    int gap;
    logic [7:0] pre[7];
    rst = 1'b1; rx_valid = 0; rx_byte = 0; cs_n = 1;
    result = 32'hCAFEF00D; stream = 32'hDEADBEEF;
    model_reset();
    #1;
    chk("reset.cmd_valid", cmd_valid, 0);
    chk("reset.tx", tx_byte, 0);
    chk("reset.addr", address, 0);
    chk("reset.value", value, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // WRITE
    pre = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
    foreach (pre[i]) addv(1, pre[i], 0, 0, 0, 0, 8'h00, 8'h00, 24'h0, 32'h0);
    addv(1, 8'h44, 0, 1, 0, 0, 8'h00, 8'h01, 24'hAABBCC, 32'h11223344);
    addv(0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h01, 24'hAABBCC, 32'h11223344);
    // READ
    addv(1, 8'h02, 0, 0, 0, 0, 8'h00, 8'h01, 24'hAABBCC, 32'h11223344);
    addv(1, 8'h12, 0, 0, 0, 0, 8'h00, 8'h01, 24'hAABBCC, 32'h11223344);
    addv(1, 8'h34, 0, 0, 0, 0, 8'h00, 8'h01, 24'hAABBCC, 32'h11223344);
    addv(1, 8'h56, 0, 1, 0, 0, 8'h00, 8'h02, 24'h123456, 32'h0);
    // STREAM
    addv(1, 8'h03, 0, 0, 0, 0, 8'hDE, 8'h02, 24'h123456, 32'h0);
    addv(1, 8'h00, 0, 0, 0, 0, 8'hAD, 8'h02, 24'h123456, 32'h0);
    addv(1, 8'h00, 0, 0, 0, 0, 8'hBE, 8'h02, 24'h123456, 32'h0);
    addv(1, 8'h00, 0, 0, 0, 0, 8'hEF, 8'h02, 24'h123456, 32'h0);
    addv(1, 8'h00, 0, 1, 0, 0, 8'h00, 8'h03, 24'h0, 32'h0);
    // TRANSFER x5, REPEAT, TRANSFER
    addv(1, 8'h07, 0, 1, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h07, 0, 1, 0, 0, 8'hFE, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h07, 0, 1, 0, 0, 8'hF0, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h07, 0, 1, 0, 0, 8'h0D, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h07, 0, 1, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h08, 0, 1, 0, 0, 8'hCA, 8'h08, 24'h0, 32'h0);
    addv(1, 8'h07, 0, 1, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    // Chip-select abort, then READ
    addv(1, 8'h01, 0, 0, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'hAA, 0, 0, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'hBB, 0, 0, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(0, 8'h00, 1, 0, 1, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h02, 0, 0, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h0A, 0, 0, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h0B, 0, 0, 0, 0, 8'hCA, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h0C, 0, 1, 0, 0, 8'hCA, 8'h02, 24'h0A0B0C, 32'h0);
    // Unknown opcodes
    addv(1, 8'h2A, 0, 0, 0, 1, 8'hCA, 8'h02, 24'h0A0B0C, 32'h0);
    addv(1, 8'h00, 0, 0, 0, 1, 8'hCA, 8'h02, 24'h0A0B0C, 32'h0);
    addv(1, 8'h09, 0, 0, 0, 1, 8'hCA, 8'h02, 24'h0A0B0C, 32'h0);
    // Byte ignored while deselected in IDLE; next TRANSFER continues at index 1
    addv(1, 8'h01, 1, 0, 0, 0, 8'hCA, 8'h02, 24'h0A0B0C, 32'h0);
    addv(1, 8'h07, 0, 1, 0, 0, 8'hFE, 8'h07, 24'h0, 32'h0);
    // Abort wins over a simultaneous byte
    addv(1, 8'h02, 0, 0, 0, 0, 8'hFE, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h11, 0, 0, 0, 0, 8'hFE, 8'h07, 24'h0, 32'h0);
    addv(1, 8'h22, 1, 0, 1, 0, 8'hFE, 8'h07, 24'h0, 32'h0);
    addv(0, 8'h00, 1, 0, 0, 0, 8'hFE, 8'h07, 24'h0, 32'h0);

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].b, vecs[i].cs);
      chk($sformatf("vec%0d.cmd_valid", i), cmd_valid, vecs[i].cmd);
      chk($sformatf("vec%0d.abort", i), abort, vecs[i].ab);
      chk($sformatf("vec%0d.error", i), error, vecs[i].er);
      chk($sformatf("vec%0d.tx", i), tx_byte, vecs[i].tx);
      chk($sformatf("vec%0d.instr", i), instruction, vecs[i].ins);
      chk($sformatf("vec%0d.addr", i), address, vecs[i].ad);
      chk($sformatf("vec%0d.value", i), value, vecs[i].va);
    end

    // Timeout: abort on exactly the T-th idle clock after the opcode
    apply(1, 8'h02, 0);
    check_model("to_op");
    first_abort = 0;
    for (int k = 1; k <= T + 4; k++) begin
      apply(0, 8'h00, 0);
      check_model("to_idle");
      if (abort && first_abort == 0) first_abort = k;
    end
    chk("timeout_cycle", first_abort, T);
    apply(1, 8'h2A, 0);
    chk("after_timeout.error", error, 1);
    check_model("after_timeout");

    // Reset mid-frame
    apply(1, 8'h01, 0);
    apply(1, 8'hAA, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.cmd_valid", cmd_valid, 0);
    chk("midrst.abort", abort, 0);
    chk("midrst.error", error, 0);
    chk("midrst.tx", tx_byte, 0);
    chk("midrst.instr", instruction, 0);
    chk("midrst.addr", address, 0);
    chk("midrst.value", value, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apply(0, 8'h00, 0);
    check_model("post_rst");
    pre = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03};
    foreach (pre[i]) begin
      apply(1, pre[i], 0);
      check_model("post_rst_write");
    end
    apply(1, 8'h04, 0);
    check_model("post_rst_write_end");
    chk("post_rst_write.value", value, 32'h01020304);

    // Randomized traffic
    gap = 0;
    for (int n = 0; n < 3000; n++) begin
      logic v, cs;
      logic [7:0] b;
      stream = $urandom;
      result = $urandom;
      cs = ($urandom_range(0, 99) < 3);
      if (gap > 0) begin
        v = 0;
        gap--;
      end else begin
        v = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 149) == 0) gap = $urandom_range(8, 24);
      end
      if ($urandom_range(0, 9) < 6) b = 8'($urandom_range(1, 8));
      else b = 8'($urandom);
      apply(v, b, cs);
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
